// File: rtl/nextasic_pkg.sv
// Shared definitions for the NeXT sound/keyboard serial link: opcodes used by
// both the inbound decoder and the outbound encoder, frame geometry, the
// transmitter state encoding and the shifter command set.
package nextasic_pkg;

    // Outbound (monitor -> host) opcodes
    localparam logic [7:0] OP_AREQ = 8'h07;
    localparam logic [7:0] OP_MIC  = 8'hC7;
    localparam logic [7:0] OP_KBD  = 8'hC6;

    // Inbound (host -> monitor) opcodes, kept here so both directions agree
    localparam logic [7:0] OP_IN_C4 = 8'hC4;
    localparam logic [7:0] OP_IN_C5 = 8'hC5;
    localparam logic [7:0] OP_IN_C7 = 8'hC7;
    localparam logic [7:0] OP_IN_03 = 8'h03;
    localparam logic [7:0] OP_IN_0B = 8'h0B;
    localparam logic [7:0] OP_IN_FF = 8'hFF;

    // Frame geometry: start bit + 24 op bits + stop bit
    localparam int unsigned OP_BITS    = 24;
    localparam int unsigned FRAME_BITS = 26;

    // Bit counter value reached once the final op bit is on the line
    localparam logic [4:0] LAST_CNT = 5'd24;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WAIT  = 3'd1,
        START = 3'd2,
        DATA  = 3'd3,
        STOP  = 3'd4
    } tx_state_e;

    // Commands from the framing FSM to the shifter
    typedef enum logic [2:0] {
        CMD_HOLD  = 3'd0,
        CMD_LOAD  = 3'd1,
        CMD_START = 3'd2,
        CMD_FIRST = 3'd3,
        CMD_NEXT  = 3'd4,
        CMD_STOP  = 3'd5
    } sh_cmd_e;

    // Pack an opcode and its two data bytes into a 24-bit op, opcode first
    function automatic logic [23:0] pack_op(input logic [7:0] opcode, input logic [15:0] data);
        return {opcode, data};
    endfunction

endpackage

// File: rtl/op_tx_shifter.sv
// Serialiser for one outbound op: holds the 24-bit shift register, the bit
// counter and the registered line driver. It only acts on commands from the
// framing FSM, so every change of tx_out lines up with a bit_tick.
module op_tx_shifter
    import nextasic_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  sh_cmd_e     i_cmd,
    input  logic [23:0] i_op,
    output logic [4:0]  o_cnt,
    output logic        o_tx_out
);

    logic [23:0] r_sr;
    logic [4:0]  r_cnt;
    logic        r_tx_out;

    // Load, start-bit, shift and stop-bit actions on the serial line
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sr     <= 24'd0;
            r_cnt    <= 5'd0;
            r_tx_out <= 1'b1;
        end else begin
            case (i_cmd)
                CMD_LOAD: begin
                    r_sr  <= i_op;
                    r_cnt <= 5'd0;
                end
                CMD_START: begin
                    r_tx_out <= 1'b0;
                end
                CMD_FIRST: begin
                    r_tx_out <= r_sr[23];
                    r_sr     <= {r_sr[22:0], 1'b0};
                    r_cnt    <= 5'd1;
                end
                CMD_NEXT: begin
                    r_tx_out <= r_sr[23];
                    r_sr     <= {r_sr[22:0], 1'b0};
                    // The FSM never issues NEXT at LAST_CNT; saturate anyway so the count cannot wrap
                    r_cnt    <= (r_cnt == LAST_CNT) ? r_cnt : r_cnt + 5'd1;
                end
                CMD_STOP: begin
                    r_tx_out <= 1'b1;
                end
                default: begin
                    r_sr     <= r_sr;
                    r_cnt    <= r_cnt;
                    r_tx_out <= r_tx_out;
                end
            endcase
        end
    end

    assign o_cnt    = r_cnt;
    assign o_tx_out = r_tx_out;

endmodule

// File: rtl/op_encoder.sv
// Monitor-side transmitter for the NeXT sound/keyboard link. Arbitrates the
// audio-request, mic and keyboard sources (fixed priority areq > mic > kbd),
// issues a one-cycle ready to the winner, and frames the 3-byte op as
// start bit, 24 bits MSB first, stop bit, one bit per bit_tick.
module op_encoder
    import nextasic_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        bit_tick,
    input  logic        areq_valid,
    output logic        areq_ready,
    input  logic        mic_valid,
    input  logic [15:0] mic_data,
    output logic        mic_ready,
    input  logic        kbd_valid,
    input  logic [15:0] kbd_data,
    output logic        kbd_ready,
    output logic        tx_out,
    output logic        tx_busy,
    output logic        tx_done
);

    tx_state_e   r_state;
    tx_state_e   w_state_next;
    sh_cmd_e     w_cmd;
    logic [2:0]  w_grant;       // one-hot {kbd, mic, areq}
    logic [23:0] w_op;
    logic [4:0]  w_cnt;
    logic        w_tx_out;

    logic [2:0]  r_ready;       // {kbd, mic, areq}
    logic [2:0]  w_ready_next;
    logic        r_busy;
    logic        w_busy_next;
    logic        r_done;
    logic        w_done_next;

    // Fixed-priority arbitration and packing of the winning op
    always_comb begin
        w_grant = 3'b000;
        w_op    = 24'd0;
        if (areq_valid) begin
            w_grant = 3'b001;
            w_op    = pack_op(OP_AREQ, 16'h0000);
        end else if (mic_valid) begin
            w_grant = 3'b010;
            w_op    = pack_op(OP_MIC, mic_data);
        end else if (kbd_valid) begin
            w_grant = 3'b100;
            w_op    = pack_op(OP_KBD, kbd_data);
        end else begin
            w_grant = 3'b000;
            w_op    = 24'd0;
        end
    end

    // Framing FSM: next state, shifter command and next handshake outputs
    always_comb begin
        w_state_next = r_state;
        w_cmd        = CMD_HOLD;
        w_ready_next = 3'b000;
        w_busy_next  = r_busy;
        w_done_next  = 1'b0;
        case (r_state)
            IDLE: begin
                // Ticks are ignored here; the frame aligns to the next tick in WAIT
                if (w_grant != 3'b000) begin
                    w_cmd        = CMD_LOAD;
                    w_ready_next = w_grant;
                    w_busy_next  = 1'b1;
                    w_state_next = WAIT;
                end else begin
                    w_state_next = IDLE;
                end
            end
            WAIT: begin
                if (bit_tick) begin
                    w_cmd        = CMD_START;
                    w_state_next = START;
                end else begin
                    w_state_next = WAIT;
                end
            end
            START: begin
                if (bit_tick) begin
                    w_cmd        = CMD_FIRST;
                    w_state_next = DATA;
                end else begin
                    w_state_next = START;
                end
            end
            DATA: begin
                if (bit_tick) begin
                    if (w_cnt == LAST_CNT) begin
                        w_cmd        = CMD_STOP;
                        w_state_next = STOP;
                    end else begin
                        w_cmd        = CMD_NEXT;
                        w_state_next = DATA;
                    end
                end else begin
                    w_state_next = DATA;
                end
            end
            STOP: begin
                if (bit_tick) begin
                    w_done_next  = 1'b1;
                    w_busy_next  = 1'b0;
                    w_state_next = IDLE;
                end else begin
                    w_state_next = STOP;
                end
            end
            default: begin
                w_busy_next  = 1'b0;
                w_state_next = IDLE;
            end
        endcase
    end

    // State register and registered ready/busy/done outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_ready <= 3'b000;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_ready <= w_ready_next;
            r_busy  <= w_busy_next;
            r_done  <= w_done_next;
        end
    end

    op_tx_shifter u_shifter (
        .clk      (clk),
        .rst      (rst),
        .i_cmd    (w_cmd),
        .i_op     (w_op),
        .o_cnt    (w_cnt),
        .o_tx_out (w_tx_out)
    );

    assign areq_ready = r_ready[0];
    assign mic_ready  = r_ready[1];
    assign kbd_ready  = r_ready[2];
    assign tx_out     = w_tx_out;
    assign tx_busy    = r_busy;
    assign tx_done    = r_done;

endmodule

// File: tb/tb_op_encoder.sv
// Directed testbench for op_encoder. A line monitor records tx_out once per
// bit_tick; frames are decoded from that stream as start/24 bits/stop and
// compared against hand-computed ops.
module tb_op_encoder;

    logic        clk;
    logic        rst;
    logic        bit_tick;
    logic        areq_valid;
    logic        areq_ready;
    logic        mic_valid;
    logic [15:0] mic_data;
    logic        mic_ready;
    logic        kbd_valid;
    logic [15:0] kbd_data;
    logic        kbd_ready;
    logic        tx_out;
    logic        tx_busy;
    logic        tx_done;

    int n_checks = 0;
    int n_errors = 0;

    // tick generator control
    int tick_auto   = 1;
    int tick_period = 4;
    int tick_cnt    = 0;

    // line monitor state
    logic q[$];
    int   n_pushed  = 0;
    int   n_popped  = 0;
    int   rdy_a     = 0;
    int   rdy_m     = 0;
    int   rdy_k     = 0;
    int   done_cnt  = 0;
    int   done_abs  = -1;

    op_encoder dut (
        .clk        (clk),
        .rst        (rst),
        .bit_tick   (bit_tick),
        .areq_valid (areq_valid),
        .areq_ready (areq_ready),
        .mic_valid  (mic_valid),
        .mic_data   (mic_data),
        .mic_ready  (mic_ready),
        .kbd_valid  (kbd_valid),
        .kbd_data   (kbd_data),
        .kbd_ready  (kbd_ready),
        .tx_out     (tx_out),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Periodic bit_tick, driven on the falling edge
    initial begin
        forever begin
            @(negedge clk);
            if (tick_auto != 0) begin
                if (tick_cnt >= tick_period - 1) begin
                    bit_tick = 1'b1;
                    tick_cnt = 0;
                end else begin
                    bit_tick = 1'b0;
                    tick_cnt = tick_cnt + 1;
                end
            end
        end
    end

    // Line monitor: one tx_out sample per tick, plus ready/done pulse counters
    initial begin
        logic tk;
        forever begin
            @(posedge clk);
            tk = bit_tick;
            @(negedge clk);
            if (tk) begin
                q.push_back(tx_out);
                n_pushed = n_pushed + 1;
            end
            if (areq_ready) rdy_a = rdy_a + 1;
            if (mic_ready)  rdy_m = rdy_m + 1;
            if (kbd_ready)  rdy_k = rdy_k + 1;
            if (tx_done) begin
                done_cnt = done_cnt + 1;
                done_abs = n_pushed - 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (obs !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic flush();
        q.delete();
        n_popped = n_pushed;
    endtask

    // Raise one source's valid, wait for its ready, then withdraw it
    task automatic send(input int src, input logic [15:0] data, input string tag);
        int guard;
        guard = 0;
        case (src)
            0: areq_valid = 1'b1;
            1: begin mic_data = data; mic_valid = 1'b1; end
            default: begin kbd_data = data; kbd_valid = 1'b1; end
        endcase
        while (!((src == 0 && areq_ready) || (src == 1 && mic_ready) || (src == 2 && kbd_ready))
               && guard < 2000) begin
            step();
            guard = guard + 1;
        end
        areq_valid = 1'b0;
        mic_valid  = 1'b0;
        kbd_valid  = 1'b0;
        check({tag, "_ready_in_time"}, 32'(guard < 2000), 32'd1);
    endtask

    // Skip idle ones, then decode start + 24 bits + stop from the line samples
    task automatic expect_frame(input string tag, input logic [23:0] exp_op,
                                output int ones, output int start_abs);
        int guard;
        logic [23:0] op;
        logic b;
        ones = 0;
        guard = 0;
        start_abs = -1;
        while (guard < 4000) begin
            if (q.size() > 0 && q[0] == 1'b1) begin
                void'(q.pop_front());
                n_popped = n_popped + 1;
                ones = ones + 1;
            end else if (q.size() >= 26) begin
                break;
            end else begin
                @(negedge clk);
                guard = guard + 1;
            end
        end
        check({tag, "_in_time"}, 32'(guard < 4000), 32'd1);
        if (guard < 4000) begin
            start_abs = n_popped;
            b = q.pop_front();
            n_popped = n_popped + 1;
            op = 24'd0;
            for (int i = 0; i < 24; i++) begin
                op = {op[22:0], q.pop_front()};
                n_popped = n_popped + 1;
            end
            b = q.pop_front();
            n_popped = n_popped + 1;
            check({tag, "_op"}, {8'd0, op}, {8'd0, exp_op});
            check({tag, "_stop"}, {31'd0, b}, 32'd1);
        end
    endtask

    initial begin
        int guard;
        int ones;
        int sabs;
        int a0, m0, k0, d0;
        logic bad_tx, bad_busy;

        rst = 1'b1; bit_tick = 1'b0;
        areq_valid = 1'b0; mic_valid = 1'b0; kbd_valid = 1'b0;
        mic_data = 16'h0000; kbd_data = 16'h0000;
        repeat (5) step();
        check("reset_outputs", {26'd0, tx_out, tx_busy, tx_done, areq_ready, mic_ready, kbd_ready},
              32'b100000);
        rst = 1'b0;
        step();

        // Idle line: tick every 4 clk, no requests
        flush();
        bad_tx = 1'b0; bad_busy = 1'b0;
        a0 = rdy_a; m0 = rdy_m; k0 = rdy_k;
        for (int i = 0; i < 50; i++) begin
            step();
            if (tx_out !== 1'b1) bad_tx = 1'b1;
            if (tx_busy !== 1'b0) bad_busy = 1'b1;
        end
        check("idle_tx_low_seen", {31'd0, bad_tx}, 32'd0);
        check("idle_busy_seen", {31'd0, bad_busy}, 32'd0);
        check("idle_ready_pulses", (rdy_a - a0) + (rdy_m - m0) + (rdy_k - k0), 32'd0);

        // Single mic frame
        flush();
        m0 = rdy_m; d0 = done_cnt;
        send(1, 16'hA55A, "mic");
        expect_frame("mic", 24'hC7A55A, ones, sabs);
        guard = 0;
        while (done_cnt == d0 && guard < 400) begin step(); guard = guard + 1; end
        check("mic_done_count", done_cnt - d0, 32'd1);
        check("mic_done_after_26_ticks", done_abs - sabs, 32'd26);
        check("mic_ready_pulses", rdy_m - m0, 32'd1);
        step();
        check("mic_busy_clear", {31'd0, tx_busy}, 32'd0);

        // All three sources at once: areq, then mic, then kbd
        flush();
        a0 = rdy_a; m0 = rdy_m; k0 = rdy_k;
        mic_data = 16'hA55A; kbd_data = 16'h0102;
        areq_valid = 1'b1; mic_valid = 1'b1; kbd_valid = 1'b1;
        guard = 0;
        while ((areq_valid || mic_valid || kbd_valid) && guard < 3000) begin
            step();
            guard = guard + 1;
            if (areq_ready) areq_valid = 1'b0;
            if (mic_ready)  mic_valid  = 1'b0;
            if (kbd_ready)  kbd_valid  = 1'b0;
        end
        check("prio_handshake_in_time", 32'(guard < 3000), 32'd1);
        expect_frame("prio_areq", 24'h070000, ones, sabs);
        expect_frame("prio_mic", 24'hC7A55A, ones, sabs);
        expect_frame("prio_kbd", 24'hC60102, ones, sabs);
        check("prio_areq_ready", rdy_a - a0, 32'd1);
        check("prio_mic_ready", rdy_m - m0, 32'd1);
        check("prio_kbd_ready", rdy_k - k0, 32'd1);

        // Back-to-back keyboard frames, tick every clock
        guard = 0;
        while (tx_busy && guard < 500) begin step(); guard = guard + 1; end
        flush();
        tick_period = 1;
        k0 = rdy_k;
        kbd_data = 16'hFFFF;
        kbd_valid = 1'b1;
        expect_frame("b2b_0", 24'hC6FFFF, ones, sabs);
        expect_frame("b2b_1", 24'hC6FFFF, ones, sabs);
        check("b2b_gap_1", 32'(ones >= 1), 32'd1);
        expect_frame("b2b_2", 24'hC6FFFF, ones, sabs);
        check("b2b_gap_2", 32'(ones >= 1), 32'd1);
        kbd_valid = 1'b0;
        check("b2b_ready_pulses", 32'((rdy_k - k0) >= 3), 32'd1);
        guard = 0;
        while (tx_busy && guard < 500) begin step(); guard = guard + 1; end
        repeat (4) step();

        // Reset during data bit 10 aborts the frame
        tick_period = 4;
        flush();
        send(1, 16'h1234, "rst_mic");
        guard = 0;
        while (guard < 2000) begin
            if (q.size() > 0 && q[0] == 1'b1) begin
                void'(q.pop_front());
                n_popped = n_popped + 1;
            end else if (q.size() >= 11) begin
                break;
            end else begin
                step();
                guard = guard + 1;
            end
        end
        check("rst_reach_bit10", 32'(guard < 2000), 32'd1);
        d0 = done_cnt; m0 = rdy_m;
        rst = 1'b1;
        step();
        check("rst_tx_high", {31'd0, tx_out}, 32'd1);
        check("rst_busy_low", {31'd0, tx_busy}, 32'd0);
        rst = 1'b0;
        repeat (20) step();
        check("rst_no_done", done_cnt - d0, 32'd0);
        check("rst_no_ready", rdy_m - m0, 32'd0);
        flush();
        send(1, 16'h5AA5, "post_rst");
        expect_frame("post_rst", 24'hC75AA5, ones, sabs);

        // Tick in the acceptance cycle is ignored
        guard = 0;
        while (tx_busy && guard < 500) begin step(); guard = guard + 1; end
        tick_auto = 0;
        bit_tick = 1'b0;
        repeat (3) step();
        flush();
        mic_data = 16'h3C3C;
        mic_valid = 1'b1;
        bit_tick = 1'b1;
        step();
        check("ack_tick_ready", {31'd0, mic_ready}, 32'd1);
        check("ack_tick_line_high", {31'd0, tx_out}, 32'd1);
        mic_valid = 1'b0;
        bit_tick = 1'b0;
        repeat (2) step();
        check("ack_tick_still_high", {31'd0, tx_out}, 32'd1);
        bit_tick = 1'b1;
        step();
        check("ack_tick_start_bit", {31'd0, tx_out}, 32'd0);
        bit_tick = 1'b0;
        tick_period = 2;
        tick_cnt = 0;
        tick_auto = 1;
        expect_frame("ack_tick", 24'hC73C3C, ones, sabs);

        repeat (10) step();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
